lcd_frame_sync_ctrl: RTL and testbench

Frame-alignment controller for the camera-to-LCD path, in the `video_clk` domain. It is the only source of the video FIFO's `aclr` and of the LCD timing generator's `rgb_rst_n`. On each camera frame start it flushes the FIFO, then prefills it to a programmable level. It then releases the timing generator and supervises the running frame for FIFO underflow, re-aligning on the next camera VS when an error occurs.

---
 rtl/lcd_frame_sync_ctrl_if.sv | 25 ++
 rtl/lcd_frame_sync_ctrl.sv | 159 +++++++++++++++
 tb/tb_lcd_frame_sync_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_frame_sync_ctrl_if.sv
// Signal bundle between the frame-sync controller and the FIFO / LCD timing side.
// The controller takes the slave view; the surrounding video path drives the master view.
interface lcd_frame_sync_ctrl_if #(
  parameter int unsigned FIFO_AW = 10
);
  logic               cam_vs;
  logic [FIFO_AW-1:0] fifo_rdusedw;
  logic               fifo_rdempty;
  logic               lcd_de;
  logic               fifo_aclr;
  logic               timing_rst_n;
  logic               sync_ok;
  logic [7:0]         underflow_cnt;
  logic [7:0]         resync_cnt;

  modport master (
    output cam_vs, fifo_rdusedw, fifo_rdempty, lcd_de,
    input  fifo_aclr, timing_rst_n, sync_ok, underflow_cnt, resync_cnt
  );

  modport slave (
    input  cam_vs, fifo_rdusedw, fifo_rdempty, lcd_de,
    output fifo_aclr, timing_rst_n, sync_ok, underflow_cnt, resync_cnt
  );
endinterface

// File: rtl/lcd_frame_sync_ctrl.sv
// Aligns the LCD timing generator to camera frames: flush the video FIFO on camera VS,
// prefill it, release the timing generator, and re-align after underflow.
module lcd_frame_sync_ctrl #(
  parameter int unsigned FIFO_AW            = 10,
  parameter int unsigned PREFILL_LEVEL      = 400,
  parameter int unsigned FLUSH_CYCLES       = 4,
  parameter int unsigned PREFILL_TIMEOUT    = 800000,
  parameter int unsigned RESYNC_EVERY_FRAME = 0
) (
  input  logic                 video_clk,
  input  logic                 rst_n,
  lcd_frame_sync_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWaitVs  = 3'd1,
    StFlush   = 3'd2,
    StPrefill = 3'd3,
    StRun     = 3'd4
  } state_e;

  localparam logic [FIFO_AW-1:0] PrefillLvl = FIFO_AW'(PREFILL_LEVEL);
  localparam logic [3:0]         FlushLast  = 4'(FLUSH_CYCLES - 1);
  localparam logic [19:0]        ToLast     = 20'(PREFILL_TIMEOUT - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_e      state_q, state_d;
  logic        s1_q, s2_q, s3_q;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic [19:0] to_cnt_q, to_cnt_d;
  logic        err_q, err_d;
  logic [7:0]  ucnt_q, ucnt_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic        aclr_q, aclr_d;
  logic        trst_n_q, trst_n_d;
  logic        ok_q, ok_d;
  logic        vs_rise;
  logic        underflow;

  // cam_vs is asynchronous: two-flop synchronizer plus one edge-detect stage.
  assign vs_rise   = s2_q & ~s3_q;
  assign underflow = bus.lcd_de & bus.fifo_rdempty;

  always_ff @(posedge video_clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      flush_cnt_q <= '0;
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
      ucnt_q      <= '0;
      rcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      s1_q        <= bus.cam_vs;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      flush_cnt_q <= flush_cnt_d;
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
      ucnt_q      <= ucnt_d;
      rcnt_q      <= rcnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    to_cnt_d    = to_cnt_q;
    err_d       = err_q;
    ucnt_d      = ucnt_q;
    rcnt_d      = rcnt_q;
    case (state_q)
      StIdle: state_d = StWaitVs;
      StWaitVs: begin
        if (vs_rise) begin
          state_d     = StFlush;
          flush_cnt_d = '0;
          err_d       = 1'b0;
        end
      end
      StFlush: begin
        flush_cnt_d = flush_cnt_q + 4'd1;
        if (flush_cnt_q == FlushLast) begin
          state_d  = StPrefill;
          to_cnt_d = '0;
        end
      end
      StPrefill: begin
        to_cnt_d = to_cnt_q + 20'd1;
        // Reaching the fill level wins over a timeout in the same cycle.
        if (bus.fifo_rdusedw >= PrefillLvl) begin
          state_d = StRun;
        end else if (to_cnt_q == ToLast) begin
          state_d = StWaitVs;
          rcnt_d  = sat_inc(rcnt_q);
        end
      end
      StRun: begin
        if (underflow) begin
          ucnt_d = sat_inc(ucnt_q);
          err_d  = 1'b1;
        end
        if (vs_rise && (err_q || underflow)) begin
          state_d     = StFlush;
          flush_cnt_d = '0;
          err_d       = 1'b0;
          rcnt_d      = sat_inc(rcnt_q);
        end else if (vs_rise && (RESYNC_EVERY_FRAME != 0)) begin
          state_d     = StFlush;
          flush_cnt_d = '0;
          err_d       = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next-state decode so they track state_q exactly.
  always_comb begin
    aclr_d   = 1'b1;
    trst_n_d = 1'b0;
    ok_d     = 1'b0;
    case (state_d)
      StPrefill: aclr_d = 1'b0;
      StRun: begin
        aclr_d   = 1'b0;
        trst_n_d = 1'b1;
        ok_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge video_clk) begin
    if (!rst_n) begin
      aclr_q   <= 1'b1;
      trst_n_q <= 1'b0;
      ok_q     <= 1'b0;
    end else begin
      aclr_q   <= aclr_d;
      trst_n_q <= trst_n_d;
      ok_q     <= ok_d;
    end
  end

  assign bus.fifo_aclr     = aclr_q;
  assign bus.timing_rst_n  = trst_n_q;
  assign bus.sync_ok       = ok_q;
  assign bus.underflow_cnt = ucnt_q;
  assign bus.resync_cnt    = rcnt_q;

endmodule

// File: tb/tb_lcd_frame_sync_ctrl.sv
// Bench for lcd_frame_sync_ctrl: two instances (re-align on error only / every frame)
// each checked cycle by cycle against a phase-level reference model through a queue.
module tb_lcd_frame_sync_ctrl;
  localparam int unsigned AW      = 10;
  localparam int unsigned LEVEL   = 400;
  localparam int unsigned FLUSH   = 4;
  localparam int unsigned TIMEOUT = 1000;

  localparam int PIdle = 0, PWait = 1, PFlush = 2, PPrefill = 3, PRun = 4;

  typedef struct packed {
    logic       aclr;
    logic       trst_n;
    logic       ok;
    logic [7:0] uc;
    logic [7:0] rc;
  } exp_t;

  logic          video_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cam_vs = 1'b0;
  logic          fifo_rdempty = 1'b0;
  logic          lcd_de = 1'b0;
  logic [AW-1:0] fifo_rdusedw = '0;

  int errors = 0;
  int checks = 0;

  always #5 video_clk = ~video_clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    lcd_frame_sync_ctrl_if #(.FIFO_AW(AW)) bus ();
    assign bus.cam_vs       = cam_vs;
    assign bus.fifo_rdusedw = fifo_rdusedw;
    assign bus.fifo_rdempty = fifo_rdempty;
    assign bus.lcd_de       = lcd_de;

    lcd_frame_sync_ctrl #(
      .FIFO_AW           (AW),
      .PREFILL_LEVEL     (LEVEL),
      .FLUSH_CYCLES      (FLUSH),
      .PREFILL_TIMEOUT   (TIMEOUT),
      .RESYNC_EVERY_FRAME(g)
    ) dut (
      .video_clk(video_clk),
      .rst_n    (rst_n),
      .bus      (bus)
    );

    // Reference model: phase plus countdown/age counters, VS seen through a sample history.
    exp_t q[$];
    int   phase;
    int   flush_left;
    int   age;
    int   uc;
    int   rc;
    bit   err;
    bit   hist[3];

    always @(posedge video_clk) begin
      bit   vsr;
      bit   uf;
      exp_t e;
      if (!rst_n) begin
        phase = PIdle;
        uc    = 0;
        rc    = 0;
        err   = 1'b0;
        hist  = '{default: 1'b0};
      end else begin
        vsr     = hist[1] && !hist[2];
        uf      = lcd_de && fifo_rdempty;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = cam_vs;
        case (phase)
          PIdle: phase = PWait;
          PWait: if (vsr) begin
            phase      = PFlush;
            flush_left = FLUSH;
          end
          PFlush: begin
            flush_left--;
            if (flush_left == 0) begin
              phase = PPrefill;
              age   = 0;
            end
          end
          PPrefill: begin
            age++;
            if (int'(fifo_rdusedw) >= int'(LEVEL)) phase = PRun;
            else if (age == int'(TIMEOUT)) begin
              phase = PWait;
              rc    = (rc < 255) ? rc + 1 : 255;
            end
          end
          default: begin
            if (uf) begin
              uc  = (uc < 255) ? uc + 1 : 255;
              err = 1'b1;
            end
            if (vsr && (err || g == 1)) begin
              if (err) rc = (rc < 255) ? rc + 1 : 255;
              err        = 1'b0;
              phase      = PFlush;
              flush_left = FLUSH;
            end
          end
        endcase
      end
      e.aclr   = (phase < PPrefill);
      e.trst_n = (phase == PRun);
      e.ok     = (phase == PRun);
      e.uc     = uc[7:0];
      e.rc     = rc[7:0];
      q.push_back(e);
    end

    always @(negedge video_clk) begin
      exp_t e;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({bus.fifo_aclr, bus.timing_rst_n, bus.sync_ok, bus.underflow_cnt,
             bus.resync_cnt} !== e) begin
          errors++;
          $display("FAIL dut%0d outputs @%0t: got aclr=%b trst_n=%b ok=%b uc=%0d rc=%0d, want aclr=%b trst_n=%b ok=%b uc=%0d rc=%0d",
                   g, $time, bus.fifo_aclr, bus.timing_rst_n, bus.sync_ok, bus.underflow_cnt,
                   bus.resync_cnt, e.aclr, e.trst_n, e.ok, e.uc, e.rc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge video_clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    // Reset
    step(3);
    chk("reset aclr", g_dut[0].bus.fifo_aclr, 1);
    chk("reset trst_n", g_dut[0].bus.timing_rst_n, 0);
    chk("reset sync_ok", g_dut[1].bus.sync_ok, 0);
    chk("reset resync_cnt", g_dut[0].bus.resync_cnt, 0);
    rst_n = 1'b1;
    step(2);

    // First alignment: long VS pulse, FIFO fills 50 cycles after flush
    cam_vs = 1'b1;
    step(56);
    chk("prefill aclr low", g_dut[0].bus.fifo_aclr, 0);
    chk("prefill sync_ok low", g_dut[0].bus.sync_ok, 0);
    fifo_rdusedw = 10'd400;
    step(1);
    chk("run trst_n", g_dut[0].bus.timing_rst_n, 1);
    chk("run sync_ok", g_dut[1].bus.sync_ok, 1);
    chk("run resync_cnt", g_dut[0].bus.resync_cnt, 0);
    step(43);
    cam_vs = 1'b0;
    step(5);

    // Three underflow cycles then VS: re-align with resync_cnt bump
    lcd_de = 1'b1;
    fifo_rdempty = 1'b1;
    step(3);
    lcd_de = 1'b0;
    fifo_rdempty = 1'b0;
    chk("underflow_cnt 3", g_dut[0].bus.underflow_cnt, 3);
    cam_vs = 1'b1;
    step(2);
    chk("still run before E2", g_dut[0].bus.sync_ok, 1);
    step(1);
    chk("flush after err vs", g_dut[0].bus.fifo_aclr, 1);
    chk("resync after err", g_dut[0].bus.resync_cnt, 1);
    step(10);
    cam_vs = 1'b0;
    step(5);

    // Prefill timeout with FIFO stuck at 399
    fifo_rdusedw = 10'd399;
    lcd_de = 1'b1;
    fifo_rdempty = 1'b1;
    step(1);
    lcd_de = 1'b0;
    fifo_rdempty = 1'b0;
    cam_vs = 1'b1;
    step(1006);
    chk("prefill last cycle aclr", g_dut[0].bus.fifo_aclr, 0);
    step(1);
    chk("timeout aclr", g_dut[0].bus.fifo_aclr, 1);
    chk("timeout resync_cnt", g_dut[0].bus.resync_cnt, 3);
    cam_vs = 1'b0;
    step(3);

    // Recover to RUN
    fifo_rdusedw = 10'd400;
    cam_vs = 1'b1;
    step(10);
    cam_vs = 1'b0;
    step(5);

    // Error-free VS: instance 0 stays, instance 1 re-aligns without counting
    cam_vs = 1'b1;
    step(3);
    chk("no-err vs stay run", g_dut[0].bus.sync_ok, 1);
    chk("every-frame flush", g_dut[1].bus.fifo_aclr, 1);
    chk("every-frame resync", g_dut[1].bus.resync_cnt, 3);
    step(10);
    cam_vs = 1'b0;
    step(5);

    // Saturation
    lcd_de = 1'b1;
    fifo_rdempty = 1'b1;
    step(300);
    lcd_de = 1'b0;
    fifo_rdempty = 1'b0;
    chk("underflow sat", g_dut[0].bus.underflow_cnt, 255);
    step(1);
    cam_vs = 1'b1;
    step(10);
    cam_vs = 1'b0;
    step(5);

    // Underflow in the same cycle as vs_rise
    cam_vs = 1'b1;
    step(2);
    lcd_de = 1'b1;
    fifo_rdempty = 1'b1;
    step(1);
    lcd_de = 1'b0;
    fifo_rdempty = 1'b0;
    chk("same-cycle flush", g_dut[0].bus.fifo_aclr, 1);
    chk("same-cycle resync", g_dut[0].bus.resync_cnt, 5);
    step(10);
    cam_vs = 1'b0;
    step(5);

    // Reset during RUN
    rst_n = 1'b0;
    step(1);
    chk("midrun reset aclr", g_dut[0].bus.fifo_aclr, 1);
    chk("midrun reset ok", g_dut[0].bus.sync_ok, 0);
    chk("midrun reset uc", g_dut[0].bus.underflow_cnt, 0);
    chk("midrun reset rc", g_dut[1].bus.resync_cnt, 0);
    rst_n = 1'b1;
    step(3);

    // Randomized traffic; some blocks keep the FIFO below level to hit timeouts
    for (int blk = 0; blk < 8; blk++) begin
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(0, 39) == 0) cam_vs = ~cam_vs;
        if (blk % 3 == 2) fifo_rdusedw = AW'($urandom_range(0, 399));
        else fifo_rdusedw = AW'($urandom_range(380, 420));
        lcd_de       = 1'($urandom_range(0, 1));
        fifo_rdempty = ($urandom_range(0, 7) == 0);
        rst_n        = ($urandom_range(0, 1499) != 0);
        step(1);
      end
    end
    rst_n = 1'b1;
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
